// File: rtl/operand_entry.sv
// Two-operand calculator entry: debounces three raw buttons and assembles a
// committed word {op, a, b} through a three-state entry sequence.
module operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_load,
    input  logic       btn_op,
    input  logic       btn_clear,
    output logic [8:0] B,
    output logic       B_valid,
    output logic [1:0] stage,
    output logic       op_pending
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StEnterA = 2'b00,
        StEnterB = 2'b01,
        StReady  = 2'b10
    } state_e;

    // Bit order for all per-button vectors: [0] load, [1] op, [2] clear.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      stable_q;
    logic [2:0]      stable_prev_q;
    logic [2:0]      press_q;
    logic [CntW-1:0] cnt_q [3];

    state_e     state_q;
    logic [3:0] a_q;
    logic       load_pulse;
    logic       op_pulse;
    logic       clear_pulse;

    assign btn_raw = {btn_clear, btn_op, btn_load};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            press_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            // Registered rising-edge detect: pulse lands the cycle after stable rises.
            press_q       <= stable_q & ~stable_prev_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntLast) begin
                    stable_q[i] <= sync2_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign load_pulse  = press_q[0];
    assign op_pulse    = press_q[1];
    assign clear_pulse = press_q[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEnterA;
            a_q        <= '0;
            op_pending <= 1'b0;
            B          <= '0;
            B_valid    <= 1'b0;
        end else begin
            B_valid <= 1'b0;
            if (clear_pulse) begin
                state_q    <= StEnterA;
                a_q        <= '0;
                op_pending <= 1'b0;
                B          <= '0;
            end else begin
                if (load_pulse) begin
                    unique case (state_q)
                        StEnterA, StReady: begin
                            a_q     <= sw;
                            state_q <= StEnterB;
                        end
                        StEnterB: begin
                            // Commit uses the operator as it stood before any coincident toggle.
                            B       <= {op_pending, a_q, sw};
                            B_valid <= 1'b1;
                            state_q <= StReady;
                        end
                        default: state_q <= StEnterA;
                    endcase
                end
                if (op_pulse) begin
                    op_pending <= ~op_pending;
                end
            end
        end
    end

    assign stage = state_q;

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 500000, number of consecutive clk cycles a synchronized button level must differ from its stable value before the stable value changes; legal range 2..2^20-1.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sw  input  4  raw value switches holding the operand nibble to capture.
REQ-005 btn_load  input  1  raw, asynchronous, bouncing push-button; captures sw into the current operand field.
REQ-006 btn_op  input  1  raw, asynchronous, bouncing push-button; toggles the pending operator.
REQ-007 btn_clear  input  1  raw, asynchronous, bouncing push-button; aborts entry and zeroes the output word.
REQ-008 B  output  9  committed calculator word {op, a[3:0], b[3:0]}; op 0 = add, 1 = subtract; feeds the display/calculation stage.
REQ-009 B_valid  output  1  single-cycle pulse on the cycle B takes a newly committed value.
REQ-010 stage  output  2  entry state for LEDs: 00 ENTER_A, 01 ENTER_B, 10 READY.
REQ-011 op_pending  output  1  current pending operator bit, for an LED.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a per-button debounce counter.
REQ-013 Debounce: while synchronized level equals stable level, counter SHALL be 0; otherwise counter SHALL increment each cycle, and when it reaches DEBOUNCE_CYCLES-1, stable SHALL take the synchronized level and counter SHALL return to 0.
REQ-014 Any cycle where the synchronized level returns to the stable level before the count completes SHALL reset the counter to 0 (bounce rejection).
REQ-015 A press pulse SHALL be asserted for exactly one cycle, the cycle after stable goes 0->1; releases SHALL generate no pulse.
REQ-016 A raw 0->1 held steady, first sampled at edge N, SHALL yield its press pulse high during the cycle after edge N+DEBOUNCE_CYCLES+2.
REQ-017 FSM states: ENTER_A, ENTER_B, READY; stage SHALL reflect the current state.
REQ-018 ENTER_A + load pulse: a_reg <= sw, state -> ENTER_B.
REQ-019 ENTER_B + load pulse: B <= {op_pending, a_reg, sw}, B_valid = 1 for that cycle, state -> READY.
REQ-020 READY + load pulse: a_reg <= sw, state -> ENTER_B; B SHALL hold its previous committed value until the next commit.
REQ-021 op pulse in any state SHALL toggle op_pending; B[8] SHALL change only at a commit (REQ-019).
REQ-022 clear pulse in any state: state -> ENTER_A, a_reg <= 0, op_pending <= 0, B <= 0, B_valid = 0.
REQ-023 Simultaneous pulses, priority: clear > load > op; when load and op coincide, the commit SHALL use op_pending before the toggle, and the toggle SHALL still take effect.
REQ-024 B SHALL be a registered output with no glitching between commits; sw SHALL be sampled only on the load-pulse cycle.

Reset
REQ-025 rst high at a rising edge: state ENTER_A, B = 0, B_valid = 0, op_pending = 0, a_reg = 0, all synchronizer flops, stable levels and debounce counters = 0; reset SHALL take effect regardless of any debounce in progress, and a button held through reset SHALL produce a press pulse only after a full debounce following rst deassertion.
REQ-026 No press pulse SHALL be generated in the cycle rst is high.

Verification (DEBOUNCE_CYCLES = 4 in bench)
REQ-027 Clean entry: sw=5, press load; sw=3, press load -> B = 9'b0_0101_0011, one B_valid pulse, stage 10.
REQ-028 Operator: press op once, then enter a=9, b=2 -> B = 9'b1_1001_0010; op_pending = 1 throughout, B[8] unchanged before commit.
REQ-029 Bounce: btn_load toggles every 2 cycles for 20 cycles, then settles high -> exactly one press pulse, 4+2 cycles after settling.
REQ-030 Re-entry: from READY with B = 0x053, enter a=1 -> B stays 0x053, stage 01; then b=1 -> B = 0x011.
REQ-031 Clear mid-entry: in ENTER_B press clear and load simultaneously -> stage 00, B = 0, no B_valid pulse.
REQ-032 Reset mid-debounce: assert rst while btn_load is high with count at 2; release rst with button still held -> press pulse only after full debounce, stage 00 before it.
